// File: rtl/mem_pkg.sv
// Shared types for the instruction/data memory arbiter.
// owner_t names the requester that owns the memory port in a given cycle.
package mem_pkg;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_req_t;

  localparam logic [3:0] WSTRB_READ = 4'b0000;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; req/gnt bit 0 is the instruction port, bit 1 the data port.
// Holds the last_owner register that breaks ties in favour of the other requester.
module rr_arb2
  import mem_pkg::*;
#(
  parameter int FIRST_PRIO = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // The requester that should win the first tie is the one NOT recorded as last owner.
  localparam owner_t RESET_OWNER = (FIRST_PRIO != 0) ? OWN_INSTR : OWN_DATA;

  owner_t last_owner;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_owner == OWN_DATA) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= RESET_OWNER;
    end else if (gnt != 2'b00) begin
      last_owner <= gnt[1] ? OWN_DATA : OWN_INSTR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data ports.
// One grant per cycle; responses follow after READ_LATENCY (0 or 1) cycles.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int FIRST_PRIO   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_re,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_a,
  output logic [31:0] m_wd,
  input  logic [31:0] m_rd
);

  logic [1:0]  gnt_raw;
  logic [1:0]  gnt;
  logic        grant;
  logic [31:0] a_q;
  mem_req_t    sel;

  rr_arb2 #(
    .FIRST_PRIO(FIRST_PRIO)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .req  ({d_req, i_req}),
    .gnt  (gnt_raw)
  );

  assign gnt   = reset ? 2'b00 : gnt_raw;
  assign grant = gnt[1] | gnt[0];
  assign i_gnt = gnt[0];
  assign d_gnt = gnt[1];

  // Idle cycles replay the last address so the memory address bus stays quiet.
  always_comb begin
    sel = '{addr: a_q, wstrb: WSTRB_READ, wdata: 32'h0};
    if (gnt[1]) begin
      sel = '{addr: d_addr, wstrb: d_wstrb, wdata: d_wdata};
    end else if (gnt[0]) begin
      sel = '{addr: i_addr, wstrb: WSTRB_READ, wdata: 32'h0};
    end
  end

  assign m_re    = grant;
  assign m_a     = sel.addr;
  assign m_wstrb = sel.wstrb;
  assign m_wd    = sel.wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= 32'h0;
    end else if (grant) begin
      a_q <= sel.addr;
    end
  end

  if (READ_LATENCY == 0) begin : g_lat0
    assign i_rvalid = gnt[0];
    assign d_rvalid = gnt[1];
    assign i_rdata  = gnt[0] ? m_rd : 32'h0;
    assign d_rdata  = (gnt[1] && (d_wstrb == WSTRB_READ)) ? m_rd : 32'h0;
  end else if (READ_LATENCY == 1) begin : g_lat1
    logic   resp_valid;
    logic   resp_is_write;
    owner_t resp_owner;

    // Async clear drops any in-flight response so nothing is returned after reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        resp_valid    <= 1'b0;
        resp_owner    <= OWN_INSTR;
        resp_is_write <= 1'b0;
      end else begin
        resp_valid <= grant;
        if (grant) begin
          resp_owner    <= gnt[1] ? OWN_DATA : OWN_INSTR;
          resp_is_write <= (sel.wstrb != WSTRB_READ);
        end
      end
    end

    assign i_rvalid = resp_valid && (resp_owner == OWN_INSTR);
    assign d_rvalid = resp_valid && (resp_owner == OWN_DATA);
    assign i_rdata  = (i_rvalid && !resp_is_write) ? m_rd : 32'h0;
    assign d_rdata  = (d_rvalid && !resp_is_write) ? m_rd : 32'h0;
  end else begin : g_bad_latency
    $error("mem_arbiter: READ_LATENCY must be 0 or 1");
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a registered-read instance and a combinational-read instance
// share the same requester stimulus, each backed by its own memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        d_req = 1'b0;
  logic [3:0]  d_wstrb = 4'h0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;

  logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, m_re1;
  logic [31:0] i_rdata1, d_rdata1, m_a1, m_wd1, rd1;
  logic [3:0]  m_wstrb1;
  logic        i_gnt0, i_rvalid0, d_gnt0, d_rvalid0, m_re0;
  logic [31:0] i_rdata0, d_rdata0, m_a0, m_wd0, rd0;
  logic [3:0]  m_wstrb0;

  logic [31:0] mem1 [256];
  logic [31:0] mem0 [256];
  logic [31:0] ref_mem [256];

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mem_arbiter #(.READ_LATENCY(1), .FIRST_PRIO(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .m_re(m_re1), .m_wstrb(m_wstrb1), .m_a(m_a1), .m_wd(m_wd1), .m_rd(rd1)
  );

  mem_arbiter #(.READ_LATENCY(0), .FIRST_PRIO(1)) dut0 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt0), .i_rvalid(i_rvalid0), .i_rdata(i_rdata0),
    .d_req(d_req), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
    .m_re(m_re0), .m_wstrb(m_wstrb0), .m_a(m_a0), .m_wd(m_wd0), .m_rd(rd0)
  );

  function automatic logic [31:0] init_word(input int k);
    case (k)
      1:       return 32'h0BADF00D;
      4:       return 32'hDEADBEEF;
      8:       return 32'h11223344;
      default: return (32'(k) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endcase
  endfunction

  // ---------------- memory models ----------------
  initial begin : mem_bsram
    for (int k = 0; k < 256; k++) mem1[k] = init_word(k);
    rd1 = 32'h0;
    forever begin
      @(posedge clk);
      if (m_re1) rd1 = mem1[m_a1[9:2]];
      for (int b = 0; b < 4; b++)
        if (m_wstrb1[b]) mem1[m_a1[9:2]][8*b +: 8] = m_wd1[8*b +: 8];
    end
  end

  initial begin : mem_comb
    for (int k = 0; k < 256; k++) mem0[k] = init_word(k);
    forever begin
      @(posedge clk);
      for (int b = 0; b < 4; b++)
        if (m_wstrb0[b]) mem0[m_a0[9:2]][8*b +: 8] = m_wd0[8*b +: 8];
    end
  end

  assign rd0 = mem0[m_a0[9:2]];

  // ---------------- scoreboard ----------------
  // Transaction-level model: winner by the "not the previous winner" rule, a word
  // memory, and a queue of responses owed by the one-cycle-latency instance.
  logic [32:0] exp_q[$];

  initial begin : scoreboard
    logic        win_i, win_d, is_wr, has, last_d;
    logic [31:0] e_a, e_wd, rdat, last_a;
    logic [3:0]  e_ws;
    logic [32:0] front;
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    last_d = 1'b0;
    last_a = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        exp_q.delete();
        last_d = 1'b0;
        last_a = 32'h0;
        n_checks++;
        if ({i_gnt1, d_gnt1, m_re1, m_wstrb1, i_rvalid1, d_rvalid1, i_rdata1, d_rdata1} !== 73'h0) begin
          n_fail++;
          $display("FAIL sb_reset_lat1: gnt=%b%b re=%b ws=%h rv=%b%b got nonzero, required all 0",
                   i_gnt1, d_gnt1, m_re1, m_wstrb1, i_rvalid1, d_rvalid1);
        end
        n_checks++;
        if ({i_gnt0, d_gnt0, m_re0, m_wstrb0, i_rvalid0, d_rvalid0, i_rdata0, d_rdata0} !== 73'h0) begin
          n_fail++;
          $display("FAIL sb_reset_lat0: gnt=%b%b re=%b ws=%h rv=%b%b got nonzero, required all 0",
                   i_gnt0, d_gnt0, m_re0, m_wstrb0, i_rvalid0, d_rvalid0);
        end
      end else begin
        if (i_req && d_req) begin
          win_d = !last_d;
          win_i = last_d;
        end else begin
          win_d = d_req;
          win_i = i_req;
        end
        e_a   = win_d ? d_addr : (win_i ? i_addr : last_a);
        e_ws  = win_d ? d_wstrb : 4'h0;
        e_wd  = win_d ? d_wdata : 32'h0;
        is_wr = win_d && (d_wstrb != 4'h0);
        rdat  = ((win_i || win_d) && !is_wr) ? ref_mem[e_a[9:2]] : 32'h0;
        has   = (exp_q.size() > 0);
        front = has ? exp_q[0] : 33'h0;

        n_checks++;
        if ({i_gnt1, d_gnt1, m_re1, m_wstrb1, m_a1, m_wd1} !== {win_i, win_d, win_i | win_d, e_ws, e_a, e_wd}) begin
          n_fail++;
          $display("FAIL sb_bus_lat1: got gnt=%b%b re=%b ws=%h a=%h wd=%h, required gnt=%b%b re=%b ws=%h a=%h wd=%h",
                   i_gnt1, d_gnt1, m_re1, m_wstrb1, m_a1, m_wd1, win_i, win_d, win_i | win_d, e_ws, e_a, e_wd);
        end
        n_checks++;
        if ({i_gnt0, d_gnt0, m_re0, m_wstrb0, m_a0, m_wd0} !== {win_i, win_d, win_i | win_d, e_ws, e_a, e_wd}) begin
          n_fail++;
          $display("FAIL sb_bus_lat0: got gnt=%b%b re=%b ws=%h a=%h wd=%h, required gnt=%b%b re=%b ws=%h a=%h wd=%h",
                   i_gnt0, d_gnt0, m_re0, m_wstrb0, m_a0, m_wd0, win_i, win_d, win_i | win_d, e_ws, e_a, e_wd);
        end
        n_checks++;
        if ({i_rvalid1, i_rdata1, d_rvalid1, d_rdata1} !==
            {has && !front[32], (has && !front[32]) ? front[31:0] : 32'h0,
             has && front[32], (has && front[32]) ? front[31:0] : 32'h0}) begin
          n_fail++;
          $display("FAIL sb_resp_lat1: got i=%b/%h d=%b/%h, required owed=%b entry=%h",
                   i_rvalid1, i_rdata1, d_rvalid1, d_rdata1, has, front);
        end
        n_checks++;
        if ({i_rvalid0, i_rdata0, d_rvalid0, d_rdata0} !==
            {win_i, win_i ? rdat : 32'h0, win_d, win_d ? rdat : 32'h0}) begin
          n_fail++;
          $display("FAIL sb_resp_lat0: got i=%b/%h d=%b/%h, required i=%b d=%b data=%h",
                   i_rvalid0, i_rdata0, d_rvalid0, d_rdata0, win_i, win_d, rdat);
        end

        if (has) void'(exp_q.pop_front());
        if (win_i || win_d) begin
          exp_q.push_back({win_d, rdat});
          last_d = win_d;
          last_a = e_a;
        end
        if (is_wr)
          for (int b = 0; b < 4; b++)
            if (e_ws[b]) ref_mem[e_a[9:2]][8*b +: 8] = e_wd[8*b +: 8];
      end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20; d_wstrb = 4'h0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({i_gnt1, d_gnt1, m_re1, m_wstrb1, i_rvalid1, d_rvalid1} !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_gating: got gnt=%b%b re=%b ws=%h rv=%b%b, required zeros",
               i_gnt1, d_gnt1, m_re1, m_wstrb1, i_rvalid1, d_rvalid1);
    end
    n_checks++;
    if ({i_rdata1, d_rdata1, i_rdata0, d_rdata0} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h %h %h %h, required 0", i_rdata1, d_rdata1, i_rdata0, d_rdata0);
    end
    #2;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_alternate();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      i_req = (k < 6); d_req = (k < 6);
      i_addr = 32'h40; d_addr = 32'h80; d_wstrb = 4'h0;
      #1;
      if (k < 6) begin
        n_checks++;
        if ({i_gnt1, d_gnt1} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL alternate_gnt[%0d]: got i/d=%b%b, required %b", k, i_gnt1, d_gnt1,
                   (k % 2 == 0) ? 2'b01 : 2'b10);
        end
      end
      if (k > 0) begin
        n_checks++;
        if ({i_rvalid1, d_rvalid1} !== (((k - 1) % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL alternate_rvalid[%0d]: got i/d=%b%b, required %b", k, i_rvalid1, d_rvalid1,
                   ((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
        end
      end
    end
  endtask

  task automatic test_ifetch();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b0;
    #1;
    n_checks++;
    if ({i_gnt1, d_gnt1, i_rvalid1, d_rvalid1} !== 4'b1000) begin
      n_fail++;
      $display("FAIL ifetch_grant: got gnt=%b%b rv=%b%b, required gnt=10 rv=00", i_gnt1, d_gnt1, i_rvalid1, d_rvalid1);
    end
    @(negedge clk);
    i_req = 1'b0;
    #1;
    n_checks++;
    if ({i_rvalid1, i_rdata1, d_gnt1, d_rvalid1, d_rdata1} !== {1'b1, 32'hDEADBEEF, 2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL ifetch_resp: got rv=%b data=%h d_gnt=%b d_rv=%b d_rd=%h, required rv=1 data=deadbeef d quiet",
               i_rvalid1, i_rdata1, d_gnt1, d_rvalid1, d_rdata1);
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    d_req = 1'b1; d_wstrb = 4'b0011; d_addr = 32'h20; d_wdata = 32'hAABBCCDD;
    #1;
    n_checks++;
    if ({d_gnt1, m_wstrb1, m_a1, m_wd1} !== {1'b1, 4'b0011, 32'h20, 32'hAABBCCDD}) begin
      n_fail++;
      $display("FAIL write_drive: got gnt=%b ws=%b a=%h wd=%h, required 1/0011/20/aabbccdd",
               d_gnt1, m_wstrb1, m_a1, m_wd1);
    end
    @(negedge clk);
    d_wstrb = 4'b0000;
    #1;
    n_checks++;
    if ({d_rvalid1, d_rdata1, d_gnt1} !== {1'b1, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL write_ack: got rv=%b data=%h gnt=%b, required rv=1 data=0 gnt=1", d_rvalid1, d_rdata1, d_gnt1);
    end
    n_checks++;
    if (d_rdata0 !== 32'h1122CCDD) begin
      n_fail++;
      $display("FAIL merge_lat0: got %h, required 1122ccdd", d_rdata0);
    end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    n_checks++;
    if ({d_rvalid1, d_rdata1} !== {1'b1, 32'h1122CCDD}) begin
      n_fail++;
      $display("FAIL merge_lat1: got rv=%b data=%h, required 1/1122ccdd", d_rvalid1, d_rdata1);
    end
  endtask

  task automatic test_lat0();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h4;
    #1;
    n_checks++;
    if ({i_gnt0, i_rvalid0, i_rdata0} !== {2'b11, 32'h0BADF00D}) begin
      n_fail++;
      $display("FAIL lat0_same_cycle: got gnt=%b rv=%b data=%h, required 1/1/0badf00d", i_gnt0, i_rvalid0, i_rdata0);
    end
    @(negedge clk);
    i_req = 1'b0;
    #1;
    n_checks++;
    if ({i_rvalid1, i_rdata1} !== {1'b1, 32'h0BADF00D}) begin
      n_fail++;
      $display("FAIL lat1_of_word1: got rv=%b data=%h, required 1/0badf00d", i_rvalid1, i_rdata1);
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_req = 1'b0; d_req = 1'b0;
      #1;
      n_checks++;
      if ({m_re1, m_wstrb1, m_a1, m_re0, m_wstrb0, m_a0} !== {5'h0, 32'h4, 5'h0, 32'h4}) begin
        n_fail++;
        $display("FAIL idle_bus[%0d]: got re=%b ws=%b a=%h / re=%b ws=%b a=%h, required 0/0000/4",
                 k, m_re1, m_wstrb1, m_a1, m_re0, m_wstrb0, m_a0);
      end
      n_checks++;
      if ({i_rvalid1, d_rvalid1, i_rvalid0, d_rvalid0} !== 4'h0) begin
        n_fail++;
        $display("FAIL idle_rvalid[%0d]: got %b%b%b%b, required 0000", k, i_rvalid1, d_rvalid1, i_rvalid0, d_rvalid0);
      end
    end
  endtask

  task automatic test_random();
    logic ig, dg;
    int   i_wait, d_wait;
    ig = 1'b0; dg = 1'b0; i_wait = 0; d_wait = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!i_req || ig) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (!d_req || dg) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_addr  = 32'($urandom_range(0, 255)) << 2;
        d_wdata = $urandom;
        d_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      end
      #1;
      ig = i_gnt1; dg = d_gnt1;
      i_wait = (i_req && !ig) ? i_wait + 1 : 0;
      d_wait = (d_req && !dg) ? d_wait + 1 : 0;
      n_checks++;
      if (i_wait > 1 || d_wait > 1) begin
        n_fail++;
        $display("FAIL random_starvation[%0d]: got waits i=%0d d=%0d, required <= 1", n, i_wait, d_wait);
      end
    end
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int nv;
    nv = 0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h30; d_req = 1'b0; d_wstrb = 4'h0;
    #1;
    n_checks++;
    if (i_gnt1 !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_grant: got %b, required 1", i_gnt1);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    d_req = 1'b1; d_addr = 32'h34; d_wstrb = 4'hF;
    #1;
    n_checks++;
    if ({i_gnt1, d_gnt1, m_re1, m_wstrb1, i_rvalid1, d_rvalid1, i_gnt0, d_gnt0, m_re0, m_wstrb0} !== 16'h0) begin
      n_fail++;
      $display("FAIL midflight_gating: got gnt=%b%b re=%b ws=%b rv=%b%b, required zeros",
               i_gnt1, d_gnt1, m_re1, m_wstrb1, i_rvalid1, d_rvalid1);
    end
    @(negedge clk);
    #3;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wstrb = 4'h0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (i_rvalid1 || d_rvalid1 || i_rvalid0 || d_rvalid0) nv++;
    end
    n_checks++;
    if (nv !== 0) begin
      n_fail++;
      $display("FAIL midflight_dropped: got %0d rvalid cycles after reset, required 0", nv);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alternate();
    test_ifetch();
    test_write();
    test_lat0();
    test_idle();
    test_random();
    test_reset_midflight();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
